// File: rtl/cordic_iter_engine_pkg.sv
// Shared types and the arctangent table for the iterative CORDIC engine.
// The table is stored at 16-bit angle resolution and scaled down on lookup.
package cordic_iter_engine_pkg;

   localparam logic [15:0] ATAN_TAB16 [0:15] = '{
      16'h4000, 16'h25C8, 16'h13F6, 16'h0A22, 16'h0516, 16'h028C, 16'h0146, 16'h00A3,
      16'h0051, 16'h0029, 16'h0014, 16'h000A, 16'h0005, 16'h0003, 16'h0001, 16'h0001
   };

   typedef enum logic { MODE_ROT = 1'b0, MODE_VEC = 1'b1 } mode_e;

   typedef enum logic [1:0] { S_IDLE, S_RUN, S_DONE } state_e;

   function automatic logic signed [15:0] atan_lookup(input logic [4:0] i, input int angle_w);
      logic signed [15:0] a;
      a = signed'(ATAN_TAB16[i[3:0]]);
      return a >>> (16 - angle_w);
   endfunction

endpackage

// File: rtl/cordic_iter_engine_if.sv
// Operation request / result bus of the CORDIC engine.
// master = requester, slave = engine.
interface cordic_iter_engine_if #(
   parameter int DATA_W  = 17,
   parameter int ANGLE_W = 16
) ();
   import cordic_iter_engine_pkg::*;

   logic                      start;
   mode_e                     mode;
   logic signed [DATA_W-1:0]  x_in;
   logic signed [DATA_W-1:0]  y_in;
   logic signed [ANGLE_W-1:0] z_in;
   logic                      ready;
   logic                      valid;
   logic signed [DATA_W-1:0]  x_out;
   logic signed [DATA_W-1:0]  y_out;
   logic signed [ANGLE_W-1:0] z_out;
   logic [4:0]                iters_used;

   modport master (
      output start, mode, x_in, y_in, z_in,
      input  ready, valid, x_out, y_out, z_out, iters_used
   );

   modport slave (
      input  start, mode, x_in, y_in, z_in,
      output ready, valid, x_out, y_out, z_out, iters_used
   );
endinterface

// File: rtl/cordic_iter_engine_micro_rot.sv
// One combinational CORDIC micro-rotation; dir_i=1 means d=+1.
// All sums wrap at the port widths.
module cordic_micro_rot #(
   parameter int DATA_W  = 17,
   parameter int ANGLE_W = 16
) (
   input  logic signed [DATA_W-1:0]  x_i,
   input  logic signed [DATA_W-1:0]  y_i,
   input  logic signed [ANGLE_W-1:0] z_i,
   input  logic [4:0]                shift_i,
   input  logic                      dir_i,
   input  logic signed [ANGLE_W-1:0] atan_i,
   output logic signed [DATA_W-1:0]  x_o,
   output logic signed [DATA_W-1:0]  y_o,
   output logic signed [ANGLE_W-1:0] z_o
);
   logic signed [DATA_W-1:0] xs, ys;

   assign xs  = x_i >>> shift_i;
   assign ys  = y_i >>> shift_i;
   assign x_o = dir_i ? (x_i - ys) : (x_i + ys);
   assign y_o = dir_i ? (y_i + xs) : (y_i - xs);
   assign z_o = dir_i ? (z_i - atan_i) : (z_i + atan_i);
endmodule

// File: rtl/cordic_iter_engine.sv
// Iterative CORDIC engine: one micro-rotation per clock, rotation or vectoring
// mode, optional early exit in vectoring once y hits exactly zero.
module cordic_iter_engine
   import cordic_iter_engine_pkg::*;
#(
   parameter int DATA_W     = 17,
   parameter int ANGLE_W    = 16,
   parameter int ITERS      = 8,
   parameter int EARLY_EXIT = 1
) (
   input logic                clk,
   input logic                rst,
   cordic_iter_engine_if.slave bus
);
   localparam logic [4:0] LAST_I = 5'(ITERS - 1);

   state_e                    state_q, state_d;
   mode_e                     mode_q, mode_d;
   logic signed [DATA_W-1:0]  x_q, x_d, y_q, y_d, xo_q, xo_d, yo_q, yo_d;
   logic signed [ANGLE_W-1:0] z_q, z_d, zo_q, zo_d;
   logic [4:0]                i_q, i_d, it_q, it_d;

   logic signed [15:0]        atan16;
   logic signed [ANGLE_W-1:0] atan_v;
   logic signed [DATA_W-1:0]  xn, yn;
   logic signed [ANGLE_W-1:0] zn;
   logic                      dir, last;

   assign atan16 = atan_lookup(i_q, ANGLE_W);
   assign atan_v = atan16[ANGLE_W-1:0];
   assign dir    = (mode_q == MODE_VEC) ? y_q[DATA_W-1] : ~z_q[ANGLE_W-1];

   cordic_micro_rot #(.DATA_W(DATA_W), .ANGLE_W(ANGLE_W)) u_rot (
      .x_i(x_q), .y_i(y_q), .z_i(z_q), .shift_i(i_q), .dir_i(dir), .atan_i(atan_v),
      .x_o(xn), .y_o(yn), .z_o(zn)
   );

   assign last = (i_q == LAST_I) ||
                 ((EARLY_EXIT != 0) && (mode_q == MODE_VEC) && (yn == '0));

   always_comb begin
      state_d = state_q;
      mode_d  = mode_q;
      x_d     = x_q;
      y_d     = y_q;
      z_d     = z_q;
      i_d     = i_q;
      xo_d    = xo_q;
      yo_d    = yo_q;
      zo_d    = zo_q;
      it_d    = it_q;
      case (state_q)
         // DONE also accepts, so a held start restarts right after the valid cycle
         S_IDLE, S_DONE: begin
            state_d = S_IDLE;
            if (bus.start) begin
               mode_d  = bus.mode;
               x_d     = bus.x_in;
               y_d     = bus.y_in;
               z_d     = bus.z_in;
               i_d     = '0;
               state_d = S_RUN;
            end
         end
         S_RUN: begin
            x_d = xn;
            y_d = yn;
            z_d = zn;
            i_d = i_q + 5'd1;
            if (last) begin
               xo_d    = xn;
               yo_d    = yn;
               zo_d    = zn;
               it_d    = i_q + 5'd1;
               state_d = S_DONE;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_IDLE;
         mode_q  <= MODE_ROT;
         x_q     <= '0;
         y_q     <= '0;
         z_q     <= '0;
         i_q     <= '0;
         xo_q    <= '0;
         yo_q    <= '0;
         zo_q    <= '0;
         it_q    <= '0;
      end else begin
         state_q <= state_d;
         mode_q  <= mode_d;
         x_q     <= x_d;
         y_q     <= y_d;
         z_q     <= z_d;
         i_q     <= i_d;
         xo_q    <= xo_d;
         yo_q    <= yo_d;
         zo_q    <= zo_d;
         it_q    <= it_d;
      end
   end

   assign bus.ready      = (state_q != S_RUN);
   assign bus.valid      = (state_q == S_DONE);
   assign bus.x_out      = xo_q;
   assign bus.y_out      = yo_q;
   assign bus.z_out      = zo_q;
   assign bus.iters_used = it_q;
endmodule

// File: tb/tb_cordic_iter_engine.sv
// Bench for cordic_iter_engine: vector table plus handshake, back-to-back and
// abort sequences on an 8-iteration (early exit) and a 16-iteration instance.
module tb_cordic_iter_engine;
   import cordic_iter_engine_pkg::*;

   localparam int DW = 17;
   localparam int AW = 16;
   localparam int ATAB [16] = '{16384, 9672, 5110, 2594, 1302, 652, 326, 163,
                                81, 41, 20, 10, 5, 3, 1, 1};

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   cyc = 0;
   int   checks = 0;
   int   failures = 0;
   int   vc8 = 0;
   int   vc16 = 0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   cordic_iter_engine_if #(.DATA_W(DW), .ANGLE_W(AW)) if8 ();
   cordic_iter_engine_if #(.DATA_W(DW), .ANGLE_W(AW)) if16 ();

   cordic_iter_engine #(.DATA_W(DW), .ANGLE_W(AW), .ITERS(8), .EARLY_EXIT(1)) dut8 (
      .clk(clk), .rst(rst), .bus(if8.slave));
   cordic_iter_engine #(.DATA_W(DW), .ANGLE_W(AW), .ITERS(16), .EARLY_EXIT(0)) dut16 (
      .clk(clk), .rst(rst), .bus(if16.slave));

   typedef struct {
      int x; int y; int z; int it; int tol; int acc; string nm;
   } exp_t;

   typedef struct {
      bit sel; bit vec; int x; int y; int z; bit um;
      int ex; int ey; int ez; int eit; string nm;
   } vec_t;

   exp_t q8[$];
   exp_t q16[$];
   vec_t tab[$];

   function automatic int wrap(input int v, input int w);
      int s;
      s = 32 - w;
      return (v <<< s) >>> s;
   endfunction

   // Reference CORDIC in plain integer arithmetic
   function automatic exp_t model(input bit vec, input int x, input int y, input int z,
                                  input int iters, input bit early, input string nm);
      exp_t e;
      int   d, nx, ny, nz;
      e.it = 0;
      for (int i = 0; i < iters; i++) begin
         if (vec) d = (y < 0) ? 1 : -1;
         else     d = (z >= 0) ? 1 : -1;
         nx = wrap(x - d * (y >>> i), DW);
         ny = wrap(y + d * (x >>> i), DW);
         nz = wrap(z - d * ATAB[i], AW);
         x = nx; y = ny; z = nz;
         e.it = i + 1;
         if (early && vec && (y == 0)) break;
      end
      e.x = x; e.y = y; e.z = z; e.tol = 0; e.acc = 0; e.nm = nm;
      return e;
   endfunction

   function automatic exp_t cexp(input int x, input int y, input int z, input int it,
                                 input string nm);
      exp_t e;
      e.x = x; e.y = y; e.z = z; e.it = it; e.tol = 0; e.acc = 0; e.nm = nm;
      return e;
   endfunction

   task automatic chk(input string nm, input int act, input int exp, input int tol);
      checks++;
      if (act < exp - tol || act > exp + tol) begin
         failures++;
         $display("FAIL %s actual=%0d expected=%0d tol=%0d", nm, act, exp, tol);
      end
   endtask

   task automatic got(input bit sel, input int x, input int y, input int z, input int it);
      exp_t e;
      if ((sel ? q16.size() : q8.size()) == 0) begin
         checks++;
         failures++;
         $display("FAIL unexpected_valid dut%0d actual x=%0d y=%0d z=%0d expected no pulse",
                  sel ? 16 : 8, x, y, z);
         return;
      end
      e = sel ? q16.pop_front() : q8.pop_front();
      chk({e.nm, "_x"}, x, e.x, e.tol);
      chk({e.nm, "_y"}, y, e.y, e.tol);
      chk({e.nm, "_z"}, z, e.z, e.tol);
      chk({e.nm, "_iters"}, it, e.it, 0);
      chk({e.nm, "_latency"}, cyc - e.acc, e.it + 1, 0);
   endtask

   task automatic monitor();
      forever begin
         @(negedge clk);
         if (if8.valid === 1'b1) begin
            vc8++;
            got(1'b0, int'(if8.x_out), int'(if8.y_out), int'(if8.z_out), int'(if8.iters_used));
         end
         if (if16.valid === 1'b1) begin
            vc16++;
            got(1'b1, int'(if16.x_out), int'(if16.y_out), int'(if16.z_out), int'(if16.iters_used));
         end
      end
   endtask

   task automatic drive(input bit sel, input bit st, input bit vec, input int x, input int y,
                        input int z);
      if (sel) begin
         if16.start = st; if16.mode = mode_e'(vec);
         if16.x_in = DW'(x); if16.y_in = DW'(y); if16.z_in = AW'(z);
      end else begin
         if8.start = st; if8.mode = mode_e'(vec);
         if8.x_in = DW'(x); if8.y_in = DW'(y); if8.z_in = AW'(z);
      end
   endtask

   task automatic launch(input bit sel, input bit vec, input int x, input int y, input int z,
                         input exp_t e);
      int n;
      n = 0;
      @(negedge clk);
      while (!(sel ? if16.ready : if8.ready) && n < 100) begin
         @(negedge clk);
         n++;
      end
      if (n >= 100) begin
         chk({e.nm, "_ready_timeout"}, 0, 1, 0);
         return;
      end
      e.acc = cyc;
      drive(sel, 1'b1, vec, x, y, z);
      if (sel) q16.push_back(e); else q8.push_back(e);
      @(posedge clk);
      #1;
      if (sel) if16.start = 1'b0; else if8.start = 1'b0;
   endtask

   task automatic drain(input bit sel);
      int n;
      n = 0;
      while ((sel ? q16.size() : q8.size()) != 0 && n < 200) begin
         @(negedge clk);
         n++;
      end
      if (n >= 200) begin
         chk("drain_timeout", 0, 1, 0);
         if (sel) q16.delete(); else q8.delete();
      end
   endtask

   initial begin
      #200000;
      $display("FAIL global_timeout actual=running expected=finished");
      $fatal(1, "timeout");
   end

   initial begin
      exp_t e;
      int   v0, c0;
      drive(1'b0, 1'b0, 1'b0, 0, 0, 0);
      drive(1'b1, 1'b0, 1'b0, 0, 0, 0);
      fork monitor(); join_none

      tab.push_back('{0, 1, 1000, 1000, 0, 0, 2000, 0, 16384, 1, "vec45"});
      tab.push_back('{0, 1, 1000, -1000, 0, 0, 2000, 0, -16384, 1, "vecn45"});
      tab.push_back('{0, 0, 1000, 0, 0, 0, 1647, 10, -147, 8, "rot0"});
      tab.push_back('{0, 1, 0, 0, 0, 0, 0, 0, 16384, 1, "vec00"});
      tab.push_back('{1, 0, 1000, 0, -32768, 1, 0, 0, 0, 0, "rotm90"});
      tab.push_back('{1, 0, 1000, 0, 32767, 1, 0, 0, 0, 0, "rotp90"});
      tab.push_back('{1, 1, 1000, 1000, 0, 1, 0, 0, 0, 0, "vec45_noexit"});
      tab.push_back('{1, 1, 3000, 4000, 0, 1, 0, 0, 0, 0, "vec34"});
      tab.push_back('{0, 1, -2000, 500, 0, 1, 0, 0, 0, 0, "vecneg"});
      tab.push_back('{1, 0, -700, 1200, 8192, 1, 0, 0, 0, 0, "rot45q"});
      tab.push_back('{0, 0, 60000, 60000, 0, 1, 0, 0, 0, 0, "wrap"});

      repeat (3) @(negedge clk);
      chk("rst_ready8", int'(if8.ready), 1, 0);
      chk("rst_valid8", int'(if8.valid), 0, 0);
      chk("rst_x8", int'(if8.x_out), 0, 0);
      chk("rst_z8", int'(if8.z_out), 0, 0);
      chk("rst_iters16", int'(if16.iters_used), 0, 0);
      chk("rst_ready16", int'(if16.ready), 1, 0);
      rst = 1'b0;

      foreach (tab[k]) begin
         if (tab[k].um)
            e = model(tab[k].vec, tab[k].x, tab[k].y, tab[k].z, tab[k].sel ? 16 : 8,
                      tab[k].sel ? 1'b0 : 1'b1, tab[k].nm);
         else
            e = cexp(tab[k].ex, tab[k].ey, tab[k].ez, tab[k].eit, tab[k].nm);
         launch(tab[k].sel, tab[k].vec, tab[k].x, tab[k].y, tab[k].z, e);
         drain(tab[k].sel);
      end

      // A second start while busy must neither queue nor disturb the first op
      v0 = vc8;
      launch(1'b0, 1'b0, 1000, 0, 0, cexp(1647, 10, -147, 8, "busy_first"));
      repeat (3) @(negedge clk);
      chk("busy_ready", int'(if8.ready), 0, 0);
      drive(1'b0, 1'b1, 1'b1, 5, 7, 100);
      @(negedge clk);
      drive(1'b0, 1'b0, 1'b1, 5, 7, 100);
      drain(1'b0);
      repeat (12) @(negedge clk);
      chk("busy_one_valid", vc8 - v0, 1, 0);
      chk("hold_x", int'(if8.x_out), 1647, 0);
      chk("hold_y", int'(if8.y_out), 10, 0);
      chk("hold_z", int'(if8.z_out), -147, 0);
      chk("hold_ready", int'(if8.ready), 1, 0);

      // start held high: three ops, each separated by its DONE cycle
      v0 = vc8;
      @(negedge clk);
      c0 = cyc;
      drive(1'b0, 1'b1, 1'b1, 1000, 1000, 0);
      for (int k = 0; k < 3; k++) begin
         e = cexp(2000, 0, 16384, 1, "b2b");
         e.acc = c0 + 2 * k;
         q8.push_back(e);
      end
      repeat (5) @(negedge clk);
      drive(1'b0, 1'b0, 1'b1, 1000, 1000, 0);
      drain(1'b0);
      repeat (4) @(negedge clk);
      chk("b2b_count", vc8 - v0, 3, 0);

      // Reset after four iterations aborts the op silently
      launch(1'b1, 1'b0, 1000, 0, 32767, model(1'b0, 1000, 0, 32767, 16, 1'b0, "aborted"));
      repeat (4) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      q16.delete();
      v0 = vc16;
      chk("abort_ready", int'(if16.ready), 1, 0);
      chk("abort_valid", int'(if16.valid), 0, 0);
      chk("abort_x", int'(if16.x_out), 0, 0);
      chk("abort_y", int'(if16.y_out), 0, 0);
      chk("abort_z", int'(if16.z_out), 0, 0);
      chk("abort_iters", int'(if16.iters_used), 0, 0);
      repeat (20) @(negedge clk);
      chk("abort_no_valid", vc16 - v0, 0, 0);
      launch(1'b1, 1'b1, 3000, -4000, 0, model(1'b1, 3000, -4000, 0, 16, 1'b0, "after_abort"));
      drain(1'b1);
      chk("after_abort_count", vc16 - v0, 1, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
